// File: rtl/ro_adc_pkg.sv
// ro_adc_pkg: shared types and constants for the ring-oscillator ADC back-end.
//   state_e   : conversion FSM states (IDLE, RUN, HOLD)
//   MODE_UP   : unsigned up-count mode
//   MODE_UPDN : comparator-steered up/down (two's complement) mode
package ro_adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_UPDN = 1'b1;

endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: synchronises one channel's ring-oscillator and comparator
// inputs and flags each synchronised 0->1 transition of the oscillator.
//   clk, rst : system clock, asynchronous active-high reset
//   ro_in    : asynchronous ring-oscillator output
//   cmp_in   : asynchronous comparator decision
//   rise     : registered one-cycle pulse per synchronised rising edge
//   cmp_out  : synchronised comparator, aligned with rise
module ro_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    input  logic cmp_in,
    output logic rise,
    output logic cmp_out
);

    localparam int unsigned MSB = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] ro_sync_q, ro_sync_d;
    logic [SYNC_STAGES-1:0] cmp_sync_q, cmp_sync_d;
    logic ro_prev_q, ro_prev_d;
    logic rise_q, rise_d;
    logic cmp_q, cmp_d;

    // Shift chains plus edge detect; cmp gets the same depth so the
    // direction sampled with an edge belongs to that edge.
    always_comb begin
        ro_sync_d  = {ro_sync_q[SYNC_STAGES-2:0], ro_in};
        cmp_sync_d = {cmp_sync_q[SYNC_STAGES-2:0], cmp_in};
        ro_prev_d  = ro_sync_q[MSB];
        rise_d     = ro_sync_q[MSB] & ~ro_prev_q;
        cmp_d      = cmp_sync_q[MSB];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_sync_q  <= '0;
            cmp_sync_q <= '0;
            ro_prev_q  <= 1'b0;
            rise_q     <= 1'b0;
            cmp_q      <= 1'b0;
        end else begin
            ro_sync_q  <= ro_sync_d;
            cmp_sync_q <= cmp_sync_d;
            ro_prev_q  <= ro_prev_d;
            rise_q     <= rise_d;
            cmp_q      <= cmp_d;
        end
    end

    assign rise    = rise_q;
    assign cmp_out = cmp_q;

endmodule

// File: rtl/ro_adc_sampler.sv
// ro_adc_sampler: multi-channel ring-oscillator ADC back-end. Counts
// synchronised oscillator edges per channel over a programmable window and
// presents the result on a valid/ready port.
//   clk, rst   : system clock, asynchronous active-high reset
//   start      : conversion request (IDLE only); captures win_len and mode
//   win_len    : window length in clk cycles (0 = immediate empty result)
//   mode       : 0 unsigned up-count, 1 comparator-steered up/down
//   ro_in      : per-channel asynchronous oscillator outputs
//   cmp_in     : per-channel asynchronous comparator outputs
//   busy       : high in RUN and HOLD
//   res_valid  : result held; res_ready completes the handshake
//   res_data   : channel k at [k*CNT_W +: CNT_W]
//   overflow   : per-channel saturation flag for the held result
module ro_adc_sampler
    import ro_adc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    mode,
    input  logic [NUM_CH-1:0]       ro_in,
    input  logic [NUM_CH-1:0]       cmp_in,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NUM_CH*CNT_W-1:0] res_data,
    output logic [NUM_CH-1:0]       overflow
);

    localparam logic [CNT_W-1:0] UMAX = '1;
    localparam logic [CNT_W-1:0] SMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] SMIN = {1'b1, {(CNT_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic               clr_c;
    logic               run_en_c;
    logic [NUM_CH-1:0]  rise_w;
    logic [NUM_CH-1:0]  cmp_w;

    // Conversion FSM; win_cnt holds the captured window length and counts it down.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        mode_d    = mode_q;
        clr_c     = 1'b0;
        run_en_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    clr_c  = 1'b1;
                    if (win_len != '0) begin
                        win_cnt_d = win_len;
                        state_d   = RUN;
                    end else begin
                        win_cnt_d = '0;
                        state_d   = HOLD;
                    end
                end
            end
            RUN: begin
                run_en_c  = 1'b1;
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_cnt_q   <= '0;
            mode_q      <= MODE_UP;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ovf_q, ovf_d;

        ro_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .ro_in  (ro_in[k]),
            .cmp_in (cmp_in[k]),
            .rise   (rise_w[k]),
            .cmp_out(cmp_w[k])
        );

        // Saturating counter: an edge that would pass a limit is dropped and flagged.
        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (clr_c) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (run_en_c && rise_w[k]) begin
                if (mode_q == MODE_UP) begin
                    if (cnt_q == UMAX) ovf_d = 1'b1;
                    else               cnt_d = cnt_q + CNT_W'(1);
                end else if (cmp_w[k]) begin
                    if (cnt_q == SMAX) ovf_d = 1'b1;
                    else               cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (cnt_q == SMIN) ovf_d = 1'b1;
                    else               cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign res_data[k*CNT_W +: CNT_W] = cnt_q;
        assign overflow[k]                = ovf_q;
    end

endmodule

// File: doc/ro_adc_sampler.md
# ro_adc_sampler

Multi-channel digital back-end for the ring-oscillator ADC front-end. Each channel's asynchronous ring-oscillator output is synchronised and its rising edges counted over a programmable window; in up/down mode the channel comparator decision steers the count direction. Completed conversions are held on a valid/ready result port for the downstream filter/decimator. One instance serves all channels of an ADC array.

## Interface
- NUM_CH, 4: number of channels, at least 1
- CNT_W, 12: per-channel count width, at least 2
- WIN_W, 16: window-length register width
- SYNC_STAGES, 2: flip-flop synchroniser depth, at least 2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  conversion request, sampled only in IDLE
- win_len  in  WIN_W  window length in clk cycles, captured with start
- mode  in  1  0 = up-count (unsigned), 1 = up/down (two's complement), captured with start
- ro_in  in  NUM_CH  ring-oscillator outputs, asynchronous
- cmp_in  in  NUM_CH  1-bit comparator outputs, asynchronous
- busy  out  1  high in RUN and HOLD
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  NUM_CH*CNT_W  channel k in bits [k*CNT_W +: CNT_W]
- overflow  out  NUM_CH  per-channel saturation flag for the held result

## Operation
- Per channel: ro_in and cmp_in each pass through SYNC_STAGES flops; a rising edge is a synchronised 0→1 transition of ro_in.
- FSM: IDLE, RUN, HOLD.
- IDLE: start=1 captures win_len and mode, clears counters and overflow flags. If win_len≠0, go to RUN with window counter = win_len. If win_len=0, go directly to HOLD with all counts 0.
- RUN: each cycle, every channel with a detected edge updates its count. The window counter decrements. On the cycle it reaches 1, that cycle's edges are counted and the next state is HOLD.
- Mode 0: count+1 on each edge. Saturates at 2^CNT_W−1, and overflow[k] is set.
- Mode 1: count+1 on an edge if synchronised cmp=1, else count−1. Signed saturation at +(2^(CNT_W−1)−1) and −2^(CNT_W−1); either limit sets overflow[k].
- HOLD: res_valid=1. res_data and overflow are stable until res_valid&&res_ready, after which the next state is IDLE.
- start outside IDLE is ignored. start in the handshake cycle is ignored.
- Reset at any time: state IDLE; all counts, overflow, busy and res_valid go to 0; synchronisers clear; captured win_len and mode clear.

## Timing
- Reset values: busy=0, res_valid=0, res_data=0, overflow=0.
- start accepted at cycle T. RUN occupies T+1 … T+win_len, and busy rises at T+1. res_valid rises at T+win_len+1.
- For win_len=0: res_valid and busy rise at T+1.
- A pin edge is counted SYNC_STAGES+1 cycles after it arrives. Edges in flight at window end are discarded; the synchronisers keep running in all states.
- ro_in is counted correctly only if its high and low phases each last at least 2 clk cycles. Faster inputs alias; this is by design.
- A handshake at cycle H gives res_valid=0 and busy=0 at H+1. The earliest next start is at H+1.
- res_data is registered; there is no combinational path from any input to any output.

## Structure
- Package ro_adc_pkg holds the state enum (IDLE, RUN, HOLD) and the mode constants MODE_UP=0 and MODE_UPDN=1.
- Sub-module ro_edge_sync: SYNC_STAGES synchroniser for ro/cmp plus the rising-edge detector. It is instantiated NUM_CH times in a generate loop.
- Counters and saturation logic live in the top level, in a per-channel generate loop.

## Test plan
- Mode 0, win_len=100, ro_in on channel 0 toggling every 5 clk (period 10) → res_data ch0 = 10 ±1, overflow=0, res_valid at T+101.
- Mode 1, CNT_W=12, 200 ro edges with cmp=1 on ch1 and cmp=0 on ch2 → ch1=+200, ch2=−200 (0xF38).
- Saturation in mode 0: CNT_W=4, 20 edges → ch=15 with overflow=1. In mode 1: 20 down edges → ch=−8 (0x8) with overflow=1.
- win_len=0 → res_valid at T+1 with all counts 0. Hold res_ready=0 for 50 cycles → data stable and start ignored. Then res_ready=1 → IDLE next cycle.
- Reset mid-RUN at cycle 30 of a 100-cycle window → all outputs 0 immediately. A new start after release gives a clean count with no residue.
- Back-to-back: handshake at H with start held high → start ignored at H and accepted at H+1; the second conversion uses the new win_len and mode.
